// File: rtl/vending_machine_pkg.sv
// Shared definitions for the vending machine controller: FSM state codes,
// coin and item encodings, their values and prices, and the credit ceiling.
package vending_machine_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ACCEPT   = 3'd1,
        ST_DISPENSE = 3'd2,
        ST_CHANGE   = 3'd3,
        ST_ERROR    = 3'd4
    } state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_20   = 2'b11;

    localparam logic [7:0] VALUE_5  = 8'd5;
    localparam logic [7:0] VALUE_10 = 8'd10;
    localparam logic [7:0] VALUE_20 = 8'd20;

    localparam logic [1:0] ITEM_NONE = 2'b00;
    localparam logic [1:0] ITEM_A    = 2'b01;
    localparam logic [1:0] ITEM_B    = 2'b10;
    localparam logic [1:0] ITEM_C    = 2'b11;

    localparam logic [7:0] PRICE_A = 8'd15;
    localparam logic [7:0] PRICE_B = 8'd20;
    localparam logic [7:0] PRICE_C = 8'd30;

    localparam logic [7:0] MAX_CREDIT = 8'd99;

    // Adds a coin value to the credit, clamping at MAX_CREDIT. The sum is
    // formed one bit wider so the comparison never sees a wrapped value.
    function automatic logic [7:0] satAdd(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, MAX_CREDIT}) ? MAX_CREDIT : sum[7:0];
    endfunction

endpackage

// File: rtl/vm_price_lut.sv
// Combinational lookup from coin code to coin value and from item code to
// item price. A "none" code maps to zero in both tables.
module vm_price_lut
    import vending_machine_pkg::*;
(
    input  logic [1:0] i_coin,
    input  logic [1:0] i_item,
    output logic [7:0] o_coinValue,
    output logic [7:0] o_itemPrice
);

    // Translate the coin code into its monetary value.
    always_comb begin
        o_coinValue = 8'd0;
        case (i_coin)
            COIN_5:  o_coinValue = VALUE_5;
            COIN_10: o_coinValue = VALUE_10;
            COIN_20: o_coinValue = VALUE_20;
            default: o_coinValue = 8'd0;
        endcase
    end

    // Translate the item code into its price.
    always_comb begin
        o_itemPrice = 8'd0;
        case (i_item)
            ITEM_A:  o_itemPrice = PRICE_A;
            ITEM_B:  o_itemPrice = PRICE_B;
            ITEM_C:  o_itemPrice = PRICE_C;
            default: o_itemPrice = 8'd0;
        endcase
    end

endmodule

// File: rtl/vending_machine.sv
// Coin-operated vending controller. Holds a saturating credit register,
// vends one of three items, and parks change or refunds on a held output.
// All outputs are decoded from registers only.
module vending_machine
    import vending_machine_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] coin,
    input  logic [1:0] item_sel,
    input  logic       cancel,
    output logic [7:0] balance,
    output logic [1:0] dispense,
    output logic [7:0] change,
    output logic       error,
    output logic [2:0] state_out
);

    state_t     r_state;
    logic [7:0] r_credit;
    logic [7:0] r_change;
    logic [1:0] r_item;

    state_t     w_nextState;
    logic [7:0] w_nextCredit;
    logic [7:0] w_nextChange;
    logic [1:0] w_nextItem;
    logic [7:0] w_coinValue;
    logic [7:0] w_itemPrice;
    logic       w_canAfford;

    vm_price_lut u_priceLut (
        .i_coin      (coin),
        .i_item      (item_sel),
        .o_coinValue (w_coinValue),
        .o_itemPrice (w_itemPrice)
    );

    assign w_canAfford = (r_credit >= w_itemPrice);

    // State and datapath registers; reset drops any credit without refund.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_credit <= 8'd0;
            r_change <= 8'd0;
            r_item   <= ITEM_NONE;
        end else begin
            r_state  <= w_nextState;
            r_credit <= w_nextCredit;
            r_change <= w_nextChange;
            r_item   <= w_nextItem;
        end
    end

    // Next-state and datapath updates. ACCEPT and ERROR share the same input
    // priority (cancel, then select, then coin), taking one action per cycle.
    always_comb begin
        w_nextState  = r_state;
        w_nextCredit = r_credit;
        w_nextChange = r_change;
        w_nextItem   = r_item;
        case (r_state)
            ST_IDLE: begin
                if (coin != COIN_NONE) begin
                    w_nextCredit = w_coinValue;
                    w_nextChange = 8'd0;
                    w_nextState  = ST_ACCEPT;
                end
            end
            ST_ACCEPT, ST_ERROR: begin
                if (cancel) begin
                    w_nextChange = r_credit;
                    w_nextCredit = 8'd0;
                    w_nextState  = ST_CHANGE;
                end else if (item_sel != ITEM_NONE) begin
                    if (w_canAfford) begin
                        w_nextCredit = r_credit - w_itemPrice;
                        w_nextItem   = item_sel;
                        w_nextState  = ST_DISPENSE;
                    end else begin
                        w_nextState  = ST_ERROR;
                    end
                end else if (coin != COIN_NONE) begin
                    w_nextCredit = satAdd(r_credit, w_coinValue);
                    w_nextState  = ST_ACCEPT;
                end
            end
            ST_DISPENSE: begin
                w_nextChange = r_credit;
                w_nextCredit = 8'd0;
                w_nextState  = ST_CHANGE;
            end
            ST_CHANGE: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    assign balance   = (r_state == ST_ERROR) ? 8'd0 : r_credit;
    assign dispense  = (r_state == ST_DISPENSE) ? r_item : ITEM_NONE;
    assign change    = r_change;
    assign error     = (r_state == ST_ERROR);
    assign state_out = r_state;

endmodule

// File: tb/tb_vending_machine.sv
// Directed testbench for the vending machine controller. Inputs are driven
// on the falling edge and outputs are compared on the falling edge after
// each rising edge, against hand-computed values.
module tb_vending_machine;

    logic       clk;
    logic       reset;
    logic [1:0] coin;
    logic [1:0] item_sel;
    logic       cancel;
    logic [7:0] balance;
    logic [1:0] dispense;
    logic [7:0] change;
    logic       error;
    logic [2:0] state_out;

    int checks = 0;
    int errors = 0;

    vending_machine dut (
        .clk       (clk),
        .reset     (reset),
        .coin      (coin),
        .item_sel  (item_sel),
        .cancel    (cancel),
        .balance   (balance),
        .dispense  (dispense),
        .change    (change),
        .error     (error),
        .state_out (state_out)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    // Drive one set of inputs across exactly one rising edge, returning on the
    // following falling edge so outputs can be sampled safely.
    task automatic applyStimulus(input logic [1:0] c, input logic [1:0] s, input logic x);
        coin     = c;
        item_sel = s;
        cancel   = x;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Compare every output against the expected values for this step.
    task automatic checkOutput(input string tag, input logic [7:0] eBal, input logic [1:0] eDisp,
                               input logic [7:0] eChg, input logic eErr, input logic [2:0] eSt);
        checks++;
        assert (balance === eBal) else begin
            errors++;
            $error("[TB] FAIL %s balance observed=%0d expected=%0d", tag, balance, eBal);
        end
        checks++;
        assert (dispense === eDisp) else begin
            errors++;
            $error("[TB] FAIL %s dispense observed=%0d expected=%0d", tag, dispense, eDisp);
        end
        checks++;
        assert (change === eChg) else begin
            errors++;
            $error("[TB] FAIL %s change observed=%0d expected=%0d", tag, change, eChg);
        end
        checks++;
        assert (error === eErr) else begin
            errors++;
            $error("[TB] FAIL %s error observed=%0d expected=%0d", tag, error, eErr);
        end
        checks++;
        assert (state_out === eSt) else begin
            errors++;
            $error("[TB] FAIL %s state_out observed=%0d expected=%0d", tag, state_out, eSt);
        end
    endtask

    // Linear sequence of directed scenarios.
    initial begin
        logic [7:0] satExp [5];
        satExp = '{8'd20, 8'd40, 8'd60, 8'd80, 8'd99};

        reset    = 1'b1;
        coin     = 2'b00;
        item_sel = 2'b00;
        cancel   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset", 8'd0, 2'd0, 8'd0, 1'b0, 3'd0);
        reset = 1'b0;

        $display("[TB] insufficient funds then cancel");
        applyStimulus(2'b10, 2'b00, 1'b0);
        checkOutput("t1_coin10", 8'd10, 2'd0, 8'd0, 1'b0, 3'd1);
        applyStimulus(2'b00, 2'b01, 1'b0);
        checkOutput("t1_selA_short", 8'd0, 2'd0, 8'd0, 1'b1, 3'd4);
        applyStimulus(2'b00, 2'b00, 1'b0);
        checkOutput("t1_err_hold", 8'd0, 2'd0, 8'd0, 1'b1, 3'd4);
        applyStimulus(2'b00, 2'b00, 1'b1);
        checkOutput("t1_err_cancel", 8'd0, 2'd0, 8'd10, 1'b0, 3'd3);
        applyStimulus(2'b00, 2'b00, 1'b0);
        checkOutput("t1_idle", 8'd0, 2'd0, 8'd10, 1'b0, 3'd0);

        $display("[TB] insert 20, select A");
        applyStimulus(2'b11, 2'b00, 1'b0);
        checkOutput("t2_coin20", 8'd20, 2'd0, 8'd0, 1'b0, 3'd1);
        applyStimulus(2'b00, 2'b01, 1'b0);
        checkOutput("t2_dispense", 8'd5, 2'd1, 8'd0, 1'b0, 3'd2);
        applyStimulus(2'b00, 2'b00, 1'b0);
        checkOutput("t2_change", 8'd0, 2'd0, 8'd5, 1'b0, 3'd3);
        applyStimulus(2'b00, 2'b00, 1'b0);
        checkOutput("t2_idle", 8'd0, 2'd0, 8'd5, 1'b0, 3'd0);

        $display("[TB] insert 10+10+10, select C");
        applyStimulus(2'b10, 2'b00, 1'b0);
        checkOutput("t3_coin1", 8'd10, 2'd0, 8'd0, 1'b0, 3'd1);
        applyStimulus(2'b10, 2'b00, 1'b0);
        checkOutput("t3_coin2", 8'd20, 2'd0, 8'd0, 1'b0, 3'd1);
        applyStimulus(2'b10, 2'b00, 1'b0);
        checkOutput("t3_coin3", 8'd30, 2'd0, 8'd0, 1'b0, 3'd1);
        applyStimulus(2'b00, 2'b11, 1'b0);
        checkOutput("t3_dispense", 8'd0, 2'd3, 8'd0, 1'b0, 3'd2);
        applyStimulus(2'b00, 2'b00, 1'b0);
        checkOutput("t3_change", 8'd0, 2'd0, 8'd0, 1'b0, 3'd3);
        applyStimulus(2'b00, 2'b00, 1'b0);
        checkOutput("t3_idle", 8'd0, 2'd0, 8'd0, 1'b0, 3'd0);

        $display("[TB] cancel and select ignored in IDLE");
        applyStimulus(2'b00, 2'b00, 1'b1);
        checkOutput("t4_idle_cancel", 8'd0, 2'd0, 8'd0, 1'b0, 3'd0);
        applyStimulus(2'b00, 2'b10, 1'b0);
        checkOutput("t4_idle_selB", 8'd0, 2'd0, 8'd0, 1'b0, 3'd0);

        $display("[TB] insert 5+10, cancel");
        applyStimulus(2'b01, 2'b00, 1'b0);
        checkOutput("t5_coin5", 8'd5, 2'd0, 8'd0, 1'b0, 3'd1);
        applyStimulus(2'b10, 2'b00, 1'b0);
        checkOutput("t5_coin10", 8'd15, 2'd0, 8'd0, 1'b0, 3'd1);
        applyStimulus(2'b00, 2'b00, 1'b1);
        checkOutput("t5_cancel", 8'd0, 2'd0, 8'd15, 1'b0, 3'd3);
        applyStimulus(2'b00, 2'b00, 1'b0);
        checkOutput("t5_idle", 8'd0, 2'd0, 8'd15, 1'b0, 3'd0);

        $display("[TB] error recovered by coin");
        applyStimulus(2'b10, 2'b00, 1'b0);
        checkOutput("t6_coin10", 8'd10, 2'd0, 8'd0, 1'b0, 3'd1);
        applyStimulus(2'b00, 2'b10, 1'b0);
        checkOutput("t6_selB_short", 8'd0, 2'd0, 8'd0, 1'b1, 3'd4);
        applyStimulus(2'b10, 2'b00, 1'b0);
        checkOutput("t6_err_coin", 8'd20, 2'd0, 8'd0, 1'b0, 3'd1);
        applyStimulus(2'b00, 2'b10, 1'b0);
        checkOutput("t6_dispense", 8'd0, 2'd2, 8'd0, 1'b0, 3'd2);
        applyStimulus(2'b00, 2'b00, 1'b0);
        checkOutput("t6_change", 8'd0, 2'd0, 8'd0, 1'b0, 3'd3);
        applyStimulus(2'b00, 2'b00, 1'b0);
        checkOutput("t6_idle", 8'd0, 2'd0, 8'd0, 1'b0, 3'd0);

        $display("[TB] affordable select straight from ERROR");
        applyStimulus(2'b01, 2'b00, 1'b0);
        applyStimulus(2'b10, 2'b00, 1'b0);
        checkOutput("t7_credit15", 8'd15, 2'd0, 8'd0, 1'b0, 3'd1);
        applyStimulus(2'b00, 2'b10, 1'b0);
        checkOutput("t7_selB_short", 8'd0, 2'd0, 8'd0, 1'b1, 3'd4);
        applyStimulus(2'b00, 2'b01, 1'b0);
        checkOutput("t7_err_selA", 8'd0, 2'd1, 8'd0, 1'b0, 3'd2);
        applyStimulus(2'b00, 2'b00, 1'b0);
        checkOutput("t7_change", 8'd0, 2'd0, 8'd0, 1'b0, 3'd3);
        applyStimulus(2'b00, 2'b00, 1'b0);
        checkOutput("t7_idle", 8'd0, 2'd0, 8'd0, 1'b0, 3'd0);

        $display("[TB] input priority");
        applyStimulus(2'b10, 2'b00, 1'b0);
        applyStimulus(2'b11, 2'b01, 1'b1);
        checkOutput("t8_cancel_wins", 8'd0, 2'd0, 8'd10, 1'b0, 3'd3);
        applyStimulus(2'b00, 2'b00, 1'b0);
        applyStimulus(2'b10, 2'b00, 1'b0);
        checkOutput("t8_coin10", 8'd10, 2'd0, 8'd0, 1'b0, 3'd1);
        applyStimulus(2'b11, 2'b01, 1'b0);
        checkOutput("t8_sel_over_coin", 8'd0, 2'd0, 8'd0, 1'b1, 3'd4);
        applyStimulus(2'b00, 2'b00, 1'b1);
        checkOutput("t8_refund", 8'd0, 2'd0, 8'd10, 1'b0, 3'd3);
        applyStimulus(2'b00, 2'b00, 1'b0);

        $display("[TB] held coin saturates, then reset mid-transaction");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2'b11, 2'b00, 1'b0);
            checkOutput($sformatf("t9_sat%0d", i), satExp[i], 2'd0, 8'd0, 1'b0, 3'd1);
        end
        coin  = 2'b11;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("t9_reset", 8'd0, 2'd0, 8'd0, 1'b0, 3'd0);
        reset = 1'b0;
        applyStimulus(2'b00, 2'b00, 1'b0);
        checkOutput("t9_after_reset", 8'd0, 2'd0, 8'd0, 1'b0, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
